// File: rtl/pmc_rx_fifo_pkg.sv
// Shared types and constants for the pixel-matrix readout capture FIFO.
package pmc_rx_fifo_pkg;

  localparam int PMC_RX_DEFAULT_DEPTH = 64;
  // Widest level field needed for the largest supported DEPTH (1024).
  localparam int PMC_RX_MAX_LVL_W     = 11;

  typedef struct packed {
    logic                        ovf;
    logic                        udf;
    logic                        full;
    logic                        empty;
    logic [PMC_RX_MAX_LVL_W-1:0] level;
  } pmc_rx_status_t;

endpackage

// File: rtl/pmc_rx_fifo_mem.sv
// Simple dual-port word storage: synchronous write, asynchronous read.
module pmc_rx_fifo_mem
  import pmc_rx_fifo_pkg::*;
#(
  parameter int DEPTH = PMC_RX_DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pmc_rx_fifo.sv
// Captures 32 column bits on each clkSh rising edge into a FWFT FIFO.
// Optional threshold/overflow interrupt enabled by defining PMC_RX_FIFO_IRQ_EN.
module pmc_rx_fifo
  import pmc_rx_fifo_pkg::*;
#(
  parameter int DEPTH = PMC_RX_DEFAULT_DEPTH,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             sh,
  input  logic             pclk,
  input  logic [31:0]      pm_dout,
  input  logic             pop,
  output logic [31:0]      rdata,
  output logic             empty,
  output logic             full,
  output logic [LVL_W-1:0] level,
  output logic             ovf,
  output logic             udf
`ifdef PMC_RX_FIFO_IRQ_EN
  ,
  input  logic [LVL_W-1:0] thr,
  output logic             irq
`endif
);

  localparam int AW = LVL_W - 1;

  logic [LVL_W-1:0] wptr_q, wptr_d;
  logic [LVL_W-1:0] rptr_q, rptr_d;
  logic             pclk_q;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             cap, push_ok, pop_ok, wr_en;
  logic [31:0]      mem_rdata;

  assign cap   = en & ~sh & pclk & ~pclk_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign pop_ok  = pop & ~empty;
  assign push_ok = cap & (~full | pop_ok);
  assign wr_en   = push_ok & ~clr & ~rst;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
    end else begin
      if (push_ok)             wptr_d = wptr_q + LVL_W'(1);
      if (pop_ok)              rptr_d = rptr_q + LVL_W'(1);
      if (cap && !push_ok)     ovf_d  = 1'b1;
      if (pop && empty)        udf_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      pclk_q <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      pclk_q <= pclk;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  pmc_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (32)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr_q[AW-1:0]),
    .wdata (pm_dout),
    .raddr (rptr_q[AW-1:0]),
    .rdata (mem_rdata)
  );

  assign rdata = empty ? 32'h0 : mem_rdata;
  assign level = wptr_q - rptr_q;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

`ifdef PMC_RX_FIFO_IRQ_EN
  logic [LVL_W-1:0] level_next;
  logic             irq_q, irq_d;

  assign level_next = wptr_d - rptr_d;
  assign irq_d      = ((level_next >= thr) && (thr != '0)) || ovf_d;

  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_pmc_rx_fifo.sv
// Scoreboard bench for pmc_rx_fifo (DEPTH=4); irq checks when PMC_RX_FIFO_IRQ_EN is defined.
module tb_pmc_rx_fifo;

  localparam int DEPTH = 4;
  localparam int LVL_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0, clr = 1'b0, sh = 1'b0, pclk = 1'b0, pop = 1'b0;
  logic [31:0]      pm_dout = '0;
  logic [31:0]      rdata;
  logic             empty, full, ovf, udf;
  logic [LVL_W-1:0] level;
`ifdef PMC_RX_FIFO_IRQ_EN
  logic [LVL_W-1:0] thr = '0;
  logic             irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pmc_rx_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .sh(sh), .pclk(pclk),
    .pm_dout(pm_dout), .pop(pop), .rdata(rdata), .empty(empty), .full(full),
    .level(level), .ovf(ovf), .udf(udf)
`ifdef PMC_RX_FIFO_IRQ_EN
    , .thr(thr), .irq(irq)
`endif
  );

  // Monitor: every accepted pop must present the next scoreboard word.
  always @(negedge clk) begin
    if (pop && !empty) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_data: got %h required no pop accepted (scoreboard empty)", rdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rdata !== e) begin
          n_fail++;
          $display("FAIL pop_data: got %h required %h", rdata, e);
        end else
          $display("pop ok: %h", rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else
      $display("check %s ok: %h", name, act);
  endtask

  task automatic pulse(input logic [31:0] w);
    pm_dout = w;
    pclk = 1'b1;
    tick();
    pclk = 1'b0;
    tick();
  endtask

  task automatic pop_one(input logic [31:0] w);
    exp_q.push_back(w);
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf",   32'(ovf),   32'd0);
    check("rst_udf",   32'(udf),   32'd0);
    check("rst_rdata", rdata,      32'd0);

    // Three captures, drained in order
    en = 1'b1;
    pulse(32'hA5A5_0001);
    pulse(32'h0000_0002);
    pulse(32'hFFFF_FFFF);
    check("three_level", 32'(level), 32'd3);
    check("three_head",  rdata,      32'hA5A5_0001);
    pop_one(32'hA5A5_0001);
    pop_one(32'h0000_0002);
    pop_one(32'hFFFF_FFFF);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_rdata", rdata,      32'd0);

    // sh=1 blocks capture
    sh = 1'b1;
    for (int i = 0; i < 5; i++) pulse(32'h5000_0000 + 32'(i));
    check("sh_level", 32'(level), 32'd0);
    sh = 1'b0;

    // pclk held high: single capture
    pm_dout = 32'h0000_1234;
    pclk = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    pclk = 1'b0;
    tick();
    check("hold_level", 32'(level), 32'd1);
    pop_one(32'h0000_1234);

    // Overfill: words 5 and 6 dropped
    for (int i = 1; i <= 6; i++) pulse(32'h11 * 32'(i));
    check("ovf_full",  32'(full),  32'd1);
    check("ovf_level", 32'(level), 32'd4);
    check("ovf_flag",  32'(ovf),   32'd1);
    check("ovf_head",  rdata,      32'h11);
    pop_one(32'h11);
    pop_one(32'h22);
    pop_one(32'h33);
    pop_one(32'h44);
    check("ovf_drained", 32'(empty), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_ovf", 32'(ovf), 32'd0);

    // Full FIFO: capture and pop together
    for (int i = 1; i <= 4; i++) pulse(32'h100 + 32'(i));
    check("fill_full", 32'(full), 32'd1);
    exp_q.push_back(32'h101);
    pm_dout = 32'h105;
    pclk = 1'b1;
    pop = 1'b1;
    tick();
    pclk = 1'b0;
    pop = 1'b0;
    tick();
    check("pp_level", 32'(level), 32'd4);
    check("pp_ovf",   32'(ovf),   32'd0);
    pop_one(32'h102);
    pop_one(32'h103);
    pop_one(32'h104);
    pop_one(32'h105);

    // Underflow
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("udf_flag",  32'(udf),   32'd1);
    check("udf_level", 32'(level), 32'd0);

    // clr concurrent with a capture
    pm_dout = 32'h0000_DEAD;
    pclk = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    pclk = 1'b0;
    tick();
    check("clr_level", 32'(level), 32'd0);
    check("clr_empty", 32'(empty), 32'd1);
    check("clr_udf",   32'(udf),   32'd0);
    check("clr_ovf2",  32'(ovf),   32'd0);

    // Re-enable while pclk high: no false edge
    en = 1'b0;
    pclk = 1'b1;
    tick();
    en = 1'b1;
    tick();
    tick();
    pclk = 1'b0;
    tick();
    check("reen_level", 32'(level), 32'd0);

    // Mid-stream reset
    pulse(32'h0000_0AAA);
    pulse(32'h0000_0BBB);
    check("pre_rst_level", 32'(level), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);

`ifdef PMC_RX_FIFO_IRQ_EN
    thr = 3'd2;
    tick();
    pulse(32'h0000_0C01);
    check("irq_one", 32'(irq), 32'd0);
    pulse(32'h0000_0C02);
    check("irq_two", 32'(irq), 32'd1);
    pop_one(32'h0000_0C01);
    check("irq_drop", 32'(irq), 32'd0);
    pop_one(32'h0000_0C02);
`endif

    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left: got %0d words pending required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pmc_rx_fifo.md
Name: pmc_rx_fifo

Overview:
- Downstream consumer of the pixel-matrix serial readout lines (pm_data.dout, 32 columns), in the same clock domain as the PMC.
- On each rising edge of the PMC-generated shift clock (clkSh) while shifting, samples all 32 column bits as one 32-bit word and pushes it into a first-word-fall-through FIFO.
- Software drains the FIFO through the PMC register window, so whole readout streams are captured without racing the PMCC program.

Parameters:
- DEPTH, 64, number of 32-bit FIFO entries; power of two, 4..1024.
- LVL_W, $clog2(DEPTH)+1, width of the fill-level output.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  capture enable (PMC control register bit).
- clr  input  1  single-cycle flush: empties the FIFO and clears the sticky flags.
- sh  input  1  pm_ctrl.shA; capture is allowed only while sh=0.
- pclk  input  1  pm_ctrl.clkSh; level signal generated in the clk domain.
- pm_dout  input  32  column serial data; bit i is column i.
- pop  input  1  consume the head word.
- rdata  output  32  head word, valid while empty=0.
- empty  output  1  FIFO empty.
- full  output  1  FIFO full.
- level  output  LVL_W  current number of entries.
- ovf  output  1  sticky: a word was dropped because the FIFO was full.
- udf  output  1  sticky: pop was asserted while empty.

Behaviour:
- One clock, clk. Reset is synchronous and active-high; all state changes on posedge clk.
- Reset values: empty=1, full=0, level=0, ovf=0, udf=0, rdata=0. Pointers=0, pclk_q=0.
- Edge detection:
  - pclk_q <= pclk every cycle.
  - cap = en & ~sh & pclk & ~pclk_q.
  - pm_dout is sampled in the same cycle as cap.
- Push:
  - If cap and the FIFO is not full, mem[wptr] <= pm_dout, wptr increments, and level increments.
  - Result is visible next cycle: empty=0, rdata equals the word.
  - Write-to-read latency is 1 cycle.
- Pop:
  - If pop and the FIFO is not empty, rptr increments and level decrements.
  - rdata always shows mem[rptr] (FWFT, combinational from registered pointer).
- Simultaneous push and pop:
  - When not empty, both happen and level is unchanged.
  - When empty, only the push happens; the pop counts as an underflow (udf <= 1).
  - When full, both happen (the pop frees a slot); no overflow.
- Push while full with no pop: the word is dropped, ovf <= 1, pointers unchanged.
- Pop while empty: no pointer change, udf <= 1.
- Pointers are LVL_W bits wide, and wrap naturally modulo 2*DEPTH.
  - full = (wptr[MSB] != rptr[MSB]) & (wptr[low] == rptr[low]).
  - empty = (wptr == rptr).
  - level = wptr - rptr.
- clr has priority over push and pop in the same cycle: pointers -> 0, ovf/udf -> 0, any capture in that cycle is discarded. Memory contents are not cleared.
- en=0: no capture. pclk_q still tracks pclk, so re-enabling while pclk=1 does not produce a false edge.
- rst mid-stream behaves like clr and additionally zeroes pclk_q. The next capture requires a fresh 0->1 transition of pclk.
- rdata reads 0 when empty; the output is gated.

Optional Feature:
- Macro: PMC_RX_FIFO_IRQ_EN.
- When defined:
  - Adds output irq (1 bit) and input thr (LVL_W bits).
  - irq is registered: irq <= (level_next >= thr & thr != 0) | ovf_next.
  - Reset value is 0; cleared by clr.
- When undefined: no irq/thr ports and no logic.

Decomposition:
- Package pmc_rx_fifo_pkg holds:
  - typedef pmc_rx_status_t, a packed struct {ovf, udf, full, empty, level} for register readout;
  - constant PMC_RX_DEFAULT_DEPTH = 64.
- Sub-module pmc_rx_fifo_mem: simple dual-port storage with synchronous write and asynchronous read. Control, pointers and flags stay in pmc_rx_fifo.

Test Plan:
- Reset, then en=1, sh=0, three pclk pulses with pm_dout = 0xA5A5_0001, 0x0000_0002, 0xFFFF_FFFF -> level=3. Popping returns the three words in order; empty=1 after the third pop.
- sh=1 during 5 pclk pulses -> level stays 0. pclk held high for 10 cycles -> exactly one word captured.
- DEPTH=4: six pulses without pop -> full=1, level=4, ovf=1. The head equals the first word; the 5th and 6th words are absent.
- Full FIFO with cap and pop in the same cycle -> level stays 4, ovf stays 0, the new word is at the tail.
- Pop on empty -> udf=1. clr in the same cycle as a cap -> level=0, ovf=udf=0, empty=1.
- With PMC_RX_FIFO_IRQ_EN and thr=2: the second captured word raises irq one cycle later. Popping to level 1 drops irq.
